cpu_bus_responder: RTL and testbench

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Byte-wide memory/I/O responder for an 8-bit CPU bus, with a streaming loader
// that holds the CPU in reset while a program image is written into RAM.
//
// Memory map:
//    0x0000 .. 2^RAM_AW-1   RAM
//    0x6000                 I/O output register (only with BUS_IO_PORT_EN)
//    0xFFFC / 0xFFFD        reset vector, low / high byte
//    everything else        unmapped, reads UNMAPPED_DATA, writes dropped
//
// Optional feature macro: BUS_IO_PORT_EN
//    Defined   -> 0x6000 is a readable/writable output register with a strobe.
//    Undefined -> 0x6000 is unmapped, io_out is 8'h00 and io_strobe is 0.
//
// Loader sequence: RUN -> LOAD (load_start) -> RELEASE (byte with load_last)
// -> RUN. The CPU is held in reset (cpu_hold) for the whole of LOAD and RELEASE.
// During that time CPU writes are dropped and CPU reads see UNMAPPED_DATA.
// RAM contents are never cleared by reset, so an aborted load keeps the bytes
// it had already written.

module cpu_bus_responder #(
   parameter int          RAM_AW        = 11,
   parameter logic [15:0] LOAD_BASE     = 16'h0200,
   parameter logic [15:0] RESET_VECTOR  = 16'h0200,
   parameter logic [7:0]  UNMAPPED_DATA = 8'hEA
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        READ_write,
   input  logic [15:0] address_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   input  logic        load_start,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        cpu_hold,
   output logic [7:0]  io_out,
   output logic        io_strobe
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int RAM_DEPTH = 1 << RAM_AW;

   localparam logic [15:0] IO_ADDR     = 16'h6000;
   localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

   // Loader pointer start value; the pointer only spans the RAM, so the
   // upper bits of LOAD_BASE are dropped and the pointer wraps in RAM.
   localparam logic [RAM_AW-1:0] PTR_INIT = LOAD_BASE[RAM_AW-1:0];
   localparam logic [RAM_AW-1:0] PTR_ONE  = {{(RAM_AW-1){1'b0}}, 1'b1};

   // FSM encoding
   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic [1:0]        state_q, state_d;
   logic [RAM_AW-1:0] ptr_q, ptr_d;

   logic              in_run;
   logic              in_load;
   logic              is_ram;

   logic              ram_we;
   logic [RAM_AW-1:0] ram_waddr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rd_q;

   logic              rsel_ram_d, rsel_ram_q;
   logic [7:0]        rdata_d, rdata_q;

   logic [7:0]        mem [0:RAM_DEPTH-1];

   // ------------------------------------------------------------------
   // Address decode and state qualifiers
   // ------------------------------------------------------------------
   assign in_run  = (state_q == ST_RUN);
   assign in_load = (state_q == ST_LOAD);
   assign is_ram  = ((address_in >> RAM_AW) == 16'h0000);

   // Status outputs follow the state register directly, so an asynchronous
   // reset drops them immediately without waiting for a clock edge.
   assign cpu_hold   = !in_run;
   assign load_ready = in_load;

   // ------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------

   // Next-state and load-pointer logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_RUN: begin
            if (load_start) begin
               state_d = ST_LOAD;
               ptr_d   = PTR_INIT;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               ptr_d = ptr_q + PTR_ONE;
               if (load_last) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and pointer registers, cleared asynchronously by reset.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         ptr_q   <= PTR_INIT;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // ------------------------------------------------------------------
   // RAM: one write port shared by CPU and loader, one registered read port
   // ------------------------------------------------------------------

   // Write-port arbitration; CPU and loader are never active in the same
   // state, so a simple priority mux suffices. A CPU write in the same cycle
   // as load_start still lands because the state is still RUN at that edge.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = address_in[RAM_AW-1:0];
      ram_wdata = data_in;
      if (in_load && load_valid) begin
         ram_we    = 1'b1;
         ram_waddr = ptr_q;
         ram_wdata = load_data;
      end else if (in_run && !READ_write && is_ram) begin
         ram_we    = 1'b1;
      end
   end

   // RAM array with registered read; deliberately not reset so contents
   // survive reset and an aborted load.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      ram_rd_q <= mem[address_in[RAM_AW-1:0]];
   end

   // ------------------------------------------------------------------
   // Optional I/O output register
   // ------------------------------------------------------------------
`ifdef BUS_IO_PORT_EN
   logic       io_we;
   logic [7:0] io_q;
   logic       io_strobe_q;

   assign io_we = in_run && !READ_write && (address_in == IO_ADDR);

   // Output register and a strobe that is high for the cycle after a write.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         io_q        <= 8'h00;
         io_strobe_q <= 1'b0;
      end else begin
         io_strobe_q <= io_we;
         if (io_we) begin
            io_q <= data_in;
         end
      end
   end

   assign io_out    = io_q;
   assign io_strobe = io_strobe_q;
`else
   assign io_out    = 8'h00;
   assign io_strobe = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------

   // Select the non-RAM read result for the address on the bus this cycle.
   // A read result is produced every cycle, whatever the bus direction.
   always_comb begin
      rsel_ram_d = 1'b0;
      rdata_d    = UNMAPPED_DATA;
      if (in_run) begin
         if (is_ram) begin
            rsel_ram_d = 1'b1;
         end else if (address_in == VEC_LO_ADDR) begin
            rdata_d = RESET_VECTOR[7:0];
         end else if (address_in == VEC_HI_ADDR) begin
            rdata_d = RESET_VECTOR[15:8];
`ifdef BUS_IO_PORT_EN
         end else if (address_in == IO_ADDR) begin
            rdata_d = io_q;
`endif
         end
      end
   end

   // Registered read selection; reset forces the output to UNMAPPED_DATA
   // while the un-reset RAM read register is masked off.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         rsel_ram_q <= 1'b0;
         rdata_q    <= UNMAPPED_DATA;
      end else begin
         rsel_ram_q <= rsel_ram_d;
         rdata_q    <= rdata_d;
      end
   end

   assign data_out = rsel_ram_q ? ram_rd_q : rdata_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder
// Directed-vector bench for cpu_bus_responder. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, so each sample shows the
// effect of the edge just taken. Honours BUS_IO_PORT_EN like the design.

module tb_cpu_bus_responder;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        READ_write;
   logic [15:0] address_in;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        load_start;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        cpu_hold;
   logic [7:0]  io_out;
   logic        io_strobe;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk_in = ~clk_in;

   cpu_bus_responder dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .READ_write (READ_write),
      .address_in (address_in),
      .data_in    (data_in),
      .data_out   (data_out),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_hold   (cpu_hold),
      .io_out     (io_out),
      .io_strobe  (io_strobe)
   );

   // Single comparison point: counts the vector and reports any miscompare.
   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus_idle();
      READ_write = 1'b1;
      address_in = 16'h4000;
      data_in    = 8'h00;
   endtask

   task automatic cpu_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
      READ_write = 1'b1;
      address_in = addr;
      step();
      check_eq(tag, {8'h00, data_out}, {8'h00, exp});
      bus_idle();
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
      READ_write = 1'b0;
      address_in = addr;
      data_in    = data;
      step();
      bus_idle();
   endtask

   task automatic load_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   // Watchdog: the stimulus is fixed-length, this only guards against a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] img [4];
      img[0] = 8'hA9; img[1] = 8'h20; img[2] = 8'h69; img[3] = 8'h05;

      reset      = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      bus_idle();

      // Reset state
      step();
      step();
      check_eq("rst data_out",   {8'h00, data_out}, 16'h00EA);
      check_eq("rst load_ready", {15'h0, load_ready}, 16'h0000);
      check_eq("rst cpu_hold",   {15'h0, cpu_hold}, 16'h0000);
      check_eq("rst io_out",     {8'h00, io_out}, 16'h0000);
      check_eq("rst io_strobe",  {15'h0, io_strobe}, 16'h0000);
      reset = 1'b1;

      // Reset vector bytes
      cpu_read(16'hFFFC, 8'h00, "vec lo");
      cpu_read(16'hFFFD, 8'h02, "vec hi");

      // Program load
      start_load();
      check_eq("load cpu_hold",   {15'h0, cpu_hold}, 16'h0001);
      check_eq("load load_ready", {15'h0, load_ready}, 16'h0001);
      for (int i = 0; i < 4; i++) begin
         load_byte(img[i], i == 3);
      end
      check_eq("release cpu_hold",   {15'h0, cpu_hold}, 16'h0001);
      check_eq("release load_ready", {15'h0, load_ready}, 16'h0000);
      step();
      check_eq("run cpu_hold",   {15'h0, cpu_hold}, 16'h0000);
      check_eq("run load_ready", {15'h0, load_ready}, 16'h0000);
      cpu_read(16'h0200, 8'hA9, "img 0200");
      cpu_read(16'h0201, 8'h20, "img 0201");
      cpu_read(16'h0202, 8'h69, "img 0202");
      cpu_read(16'h0203, 8'h05, "img 0203");

      // CPU RAM write/read, unmapped read
      cpu_write(16'h0010, 8'h55);
      cpu_read(16'h0010, 8'h55, "ram 0010");
      cpu_read(16'h4000, 8'hEA, "unmapped 4000");
      cpu_write(16'h07FF, 8'h3E);
      cpu_read(16'h07FF, 8'h3E, "ram top 07FF");
      cpu_read(16'h0800, 8'hEA, "above ram 0800");

      // I/O register
      READ_write = 1'b0;
      address_in = 16'h6000;
      data_in    = 8'h3C;
      step();
      bus_idle();
`ifdef BUS_IO_PORT_EN
      check_eq("io_out after write", {8'h00, io_out}, 16'h003C);
      check_eq("io_strobe pulse",    {15'h0, io_strobe}, 16'h0001);
      step();
      check_eq("io_strobe drop",     {15'h0, io_strobe}, 16'h0000);
      check_eq("io_out held",        {8'h00, io_out}, 16'h003C);
      cpu_read(16'h6000, 8'h3C, "io readback");
`else
      check_eq("io_out after write", {8'h00, io_out}, 16'h0000);
      check_eq("io_strobe pulse",    {15'h0, io_strobe}, 16'h0000);
      step();
      check_eq("io_strobe drop",     {15'h0, io_strobe}, 16'h0000);
      cpu_read(16'h6000, 8'hEA, "io unmapped read");
`endif

      // CPU access during LOAD, then reset abort after two bytes
      cpu_write(16'h0020, 8'h11);
      start_load();
      READ_write = 1'b0;
      address_in = 16'h0020;
      data_in    = 8'h77;
      step();
      bus_idle();
      check_eq("load cpu write rd", {8'h00, data_out}, 16'h00EA);
      cpu_read(16'h0010, 8'hEA, "load cpu read");
      load_byte(8'hB1, 1'b0);
      load_byte(8'hB2, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_eq("abort cpu_hold",   {15'h0, cpu_hold}, 16'h0000);
      check_eq("abort load_ready", {15'h0, load_ready}, 16'h0000);
      check_eq("abort data_out",   {8'h00, data_out}, 16'h00EA);
      step();
      reset = 1'b1;
      cpu_read(16'h0200, 8'hB1, "abort kept 0200");
      cpu_read(16'h0201, 8'hB2, "abort kept 0201");
      cpu_read(16'h0202, 8'h69, "abort old 0202");
      cpu_read(16'h0020, 8'h11, "load write dropped");
      cpu_read(16'h0010, 8'h55, "ram survives reset");

      // Next load restarts at LOAD_BASE
      start_load();
      load_byte(8'hC1, 1'b1);
      step();
      cpu_read(16'h0200, 8'hC1, "reload 0200");
      cpu_read(16'h0201, 8'hB2, "reload 0201");

      // CPU write coincident with load_start; load_start ignored in RELEASE
      READ_write = 1'b0;
      address_in = 16'h0030;
      data_in    = 8'h99;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      bus_idle();
      check_eq("coincident load", {15'h0, load_ready}, 16'h0001);
      load_byte(8'hD1, 1'b1);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check_eq("start in release ignored", {15'h0, cpu_hold}, 16'h0000);
      cpu_read(16'h0030, 8'h99, "coincident write");
      cpu_read(16'h0200, 8'hD1, "load3 0200");

      // load_valid ignored in RUN
      load_valid = 1'b1;
      load_data  = 8'hEE;
      load_last  = 1'b1;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      check_eq("valid in run hold", {15'h0, cpu_hold}, 16'h0000);
      cpu_read(16'h0200, 8'hD1, "valid in run 0200");
      cpu_read(16'h0201, 8'hB2, "valid in run 0201");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
